// File: rtl/dau_instr_arb_pkg.sv
// Shared definitions for the BCDU instruction-port arbiter: FSM state
// encodings, instruction width and the NOP word driven while no requester
// owns the port.
package dau_instr_arb_pkg;

    localparam int INSTR_W = 16;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN  = 2'd1,
        S_GAP  = 2'd2
    } arb_state_e;

    // BCDU NOP opcode (top nibble) with zero operands
    localparam logic [3:0]         OP_NOP    = 4'h0;
    localparam logic [INSTR_W-1:0] INSTR_NOP = {OP_NOP, 12'h000};

endpackage

// File: rtl/dau_instr_arb_rr_pick.sv
// rr_pick: combinational round-robin picker. Scans the request vector
// starting at the pointer, wrapping modulo N_REQ, and returns the first
// requester found as a one-hot vector plus a found flag.
module rr_pick
    import dau_instr_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         i_req,
    input  logic [$clog2(N_REQ)-1:0] i_ptr,
    output logic [N_REQ-1:0]         o_winner,
    output logic                     o_found
);

    localparam int PW = $clog2(N_REQ);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    // First requesting index at or after the pointer, modulo N_REQ
    always_comb begin
        // NOTE: every variable gets a default before any conditional
        // assignment, so no path leaves it unassigned and no latch appears.
        o_winner = '0;
        o_found  = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = {1'b0, i_ptr} + (PW+1)'(i);
            if (sum >= (PW+1)'(N_REQ)) begin
                sum = sum - (PW+1)'(N_REQ);
            end
            idx = sum[PW-1:0];
            if (!o_found && i_req[idx]) begin
                o_winner[idx] = 1'b1;
                o_found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dau_instr_arb.sv
// dau_instr_arb: round-robin ownership arbiter that lets N_REQ sequencers
// share one BCDU instruction port. A requester owns the port for a whole
// instruction sequence; a one-cycle gap separates consecutive owners.
// Optional ownership watchdog (and o_timeout port) when DAU_ARB_TIMEOUT_EN
// is defined.
module dau_instr_arb
    import dau_instr_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [N_REQ-1:0]           i_req,
    input  logic [N_REQ-1:0]           i_instr_valid,
    input  logic [INSTR_W*N_REQ-1:0]   i_instr,
    output logic [N_REQ-1:0]           o_instr_accept,
    output logic [N_REQ-1:0]           o_gnt,
    output logic                       o_instr_valid,
    output logic [INSTR_W-1:0]         o_instr,
    input  logic                       i_instr_accept,
    output logic                       o_busy,
    output logic                       o_proto_err
`ifdef DAU_ARB_TIMEOUT_EN
    ,
    output logic                       o_timeout
`endif
);

    localparam int PW = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("dau_instr_arb: unsupported N_REQ/TIMEOUT_CYC");
    end

    arb_state_e         state_q, state_d;
    logic [PW-1:0]      owner_q, owner_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic               proto_err_q, proto_err_d;
    logic [PW-1:0]      pick_idx;
    logic [N_REQ-1:0]   pick_onehot;
    logic               pick_found;
    logic [N_REQ-1:0]   gnt_vec;
    logic               release_now;
    logic               wd_expire;
    logic [INSTR_W-1:0] slice [N_REQ];

    for (genvar k = 0; k < N_REQ; k++) begin : g_slice
        assign slice[k] = i_instr[k*INSTR_W +: INSTR_W];
    end

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .i_req    (i_req),
        .i_ptr    (ptr_q),
        .o_winner (pick_onehot),
        .o_found  (pick_found)
    );

    // Convert the one-hot winner into an owner index
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_onehot[i]) pick_idx = PW'(i);
        end
    end

    // Grant vector: one-hot owner while in S_OWN, zero otherwise
    always_comb begin
        gnt_vec = '0;
        if (state_q == S_OWN) gnt_vec[owner_q] = 1'b1;
    end

`ifdef DAU_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            accepted;
    logic            timeout_q;

    assign accepted  = o_instr_valid & i_instr_accept;
    assign wd_expire = (state_q == S_OWN) && !accepted &&
                       (wd_q == WD_W'(TIMEOUT_CYC - 1));

    // Watchdog next value: count idle owner cycles, clear on any accept
    always_comb begin
        wd_d = '0;
        if (state_q == S_OWN && !accepted) wd_d = wd_q + 1'b1;
    end

    // Watchdog counter and one-cycle timeout pulse
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= wd_expire;
        end
    end

    assign o_timeout = timeout_q;
`else
    assign wd_expire = 1'b0;
`endif

    // Owner is done when it has dropped both request and valid (or watchdog fired)
    assign release_now = (state_q == S_OWN) &&
                         ((!i_req[owner_q] && !i_instr_valid[owner_q]) || wd_expire);

    // Next-state, owner, pointer and sticky protocol-error logic
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        proto_err_d = proto_err_q | (|(i_instr_valid & ~gnt_vec));
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    state_d = S_OWN;
                    owner_d = pick_idx;
                end
            end
            S_OWN: begin
                if (release_now) begin
                    state_d = S_GAP;
                    ptr_d   = (owner_q == PW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
                end
            end
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, owner, pointer and error registers
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (i_rst) begin
            state_q     <= S_IDLE;
            owner_q     <= '0;
            ptr_q       <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Instruction path: forward the owner's port in S_OWN, NOP otherwise
    always_comb begin
        o_instr_valid  = 1'b0;
        o_instr        = INSTR_NOP;
        o_instr_accept = '0;
        if (state_q == S_OWN) begin
            o_instr_valid           = i_instr_valid[owner_q];
            o_instr                 = slice[owner_q];
            o_instr_accept[owner_q] = i_instr_accept;
        end
    end

    assign o_gnt       = gnt_vec;
    assign o_busy      = (state_q == S_OWN);
    assign o_proto_err = proto_err_q;

endmodule

// File: tb/tb_dau_instr_arb.sv
// Directed bench for dau_instr_arb (N_REQ=4). Inputs change 1ns after the
// rising edge; outputs are checked 1ns later. Watchdog test is built only
// with DAU_ARB_TIMEOUT_EN (TIMEOUT_CYC=8).
module tb_dau_instr_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  ivalid;
    logic [63:0] instr;
    logic        acc_in;
    logic [3:0]  acc_out;
    logic [3:0]  gnt;
    logic        ovalid;
    logic [15:0] oinstr;
    logic        busy;
    logic        perr;
`ifdef DAU_ARB_TIMEOUT_EN
    logic        tmo;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dau_instr_arb #(.N_REQ(4), .TIMEOUT_CYC(8)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req          (req),
        .i_instr_valid  (ivalid),
        .i_instr        (instr),
        .o_instr_accept (acc_out),
        .o_gnt          (gnt),
        .o_instr_valid  (ovalid),
        .o_instr        (oinstr),
        .i_instr_accept (acc_in),
        .o_busy         (busy),
        .o_proto_err    (perr)
`ifdef DAU_ARB_TIMEOUT_EN
        ,
        .o_timeout      (tmo)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req = '0; ivalid = '0; instr = '0; acc_in = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        // Reset state: idle, NOP (all-zero) on the port
        check("rst_gnt",    32'(gnt),    32'h0);
        check("rst_busy",   32'(busy),   32'h0);
        check("rst_valid",  32'(ovalid), 32'h0);
        check("rst_instr",  32'(oinstr), 32'h0000);
        check("rst_accept", 32'(acc_out), 32'h0);
        check("rst_perr",   32'(perr),   32'h0);

        // Single requester, three instructions
        req = 4'b0001; #1;
        check("t1_gnt_lat0", 32'(gnt), 32'h0);
        tick();
        check("t1_gnt", 32'(gnt), 32'h1);
        check("t1_busy", 32'(busy), 32'h1);
        check("t1_novalid", 32'(ovalid), 32'h0);
        ivalid = 4'b0001; instr[15:0] = 16'h1111; acc_in = 1'b1; #1;
        check("t1_valid", 32'(ovalid), 32'h1);
        check("t1_i0", 32'(oinstr), 32'h1111);
        check("t1_acc", 32'(acc_out), 32'h1);
        tick(); instr[15:0] = 16'h2222; #1;
        check("t1_i1", 32'(oinstr), 32'h2222);
        tick(); instr[15:0] = 16'h3333; req = 4'b0000; #1;
        check("t1_i2", 32'(oinstr), 32'h3333);
        check("t1_trail_gnt", 32'(gnt), 32'h1);
        tick(); ivalid = 4'b0000; acc_in = 1'b0; #1;
        check("t1_rel_gnt", 32'(gnt), 32'h1);
        tick();
        check("t1_gap_gnt", 32'(gnt), 32'h0);
        check("t1_gap_busy", 32'(busy), 32'h0);
        check("t1_gap_valid", 32'(ovalid), 32'h0);
        tick();
        check("t1_idle_gnt", 32'(gnt), 32'h0);

        // Two simultaneous requesters from reset
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'b0101; #1;
        tick();
        check("t2_first", 32'(gnt), 32'h1);
        req = 4'b0100; #1;
        check("t2_hold", 32'(gnt), 32'h1);
        tick();
        check("t2_gap", 32'(gnt), 32'h0);
        tick();
        check("t2_idle", 32'(gnt), 32'h0);
        check("t2_idle_busy", 32'(busy), 32'h0);
        tick();
        check("t2_second", 32'(gnt), 32'h4);
        req = 4'b0000; #1;
        tick(); tick();
        // Pointer now 3: requester 3 wins over 0
        req = 4'b1001; #1;
        tick();
        check("t2_ptr3", 32'(gnt), 32'h8);
        req = 4'b0001; #1;
        tick();
        req = 4'b1001; #1;
        tick(); tick();
        // Pointer wrapped to 0 after owner 3
        check("t2_wrap", 32'(gnt), 32'h1);
        req = 4'b1000; #1;
        tick(); tick(); tick();
        check("t2_pending3", 32'(gnt), 32'h8);
        req = 4'b0000; #1;
        tick(); tick();

        // Trailing instruction stalled after request drops
        req = 4'b0010; #1;
        tick();
        check("t3_gnt", 32'(gnt), 32'h2);
        ivalid = 4'b0010; instr[31:16] = 16'hABCD; acc_in = 1'b0; req = 4'b0000; #1;
        check("t3_valid", 32'(ovalid), 32'h1);
        check("t3_instr", 32'(oinstr), 32'hABCD);
        check("t3_noacc", 32'(acc_out), 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("t3_stall%0d", i), 32'(gnt), 32'h2);
        end
        acc_in = 1'b1; #1;
        check("t3_acc", 32'(acc_out), 32'h2);
        tick(); ivalid = 4'b0000; acc_in = 1'b0; #1;
        check("t3_rel", 32'(gnt), 32'h2);
        tick();
        check("t3_gap", 32'(gnt), 32'h0);
        tick();

        // Non-owner valid sets sticky protocol error (pointer 2 wraps to 0)
        req = 4'b0001; #1;
        tick();
        check("t4_gnt", 32'(gnt), 32'h1);
        ivalid = 4'b0101; instr[15:0] = 16'h5555; instr[47:32] = 16'hEEEE; acc_in = 1'b1; #1;
        check("t4_instr", 32'(oinstr), 32'h5555);
        check("t4_acc", 32'(acc_out), 32'h1);
        check("t4_perr0", 32'(perr), 32'h0);
        tick();
        check("t4_perr1", 32'(perr), 32'h1);
        check("t4_instr2", 32'(oinstr), 32'h5555);

        // Reset during ownership
        ivalid = 4'b0000; acc_in = 1'b0; rst = 1'b1; #1;
        tick();
        check("t5_gnt", 32'(gnt), 32'h0);
        check("t5_valid", 32'(ovalid), 32'h0);
        check("t5_perr", 32'(perr), 32'h0);
        check("t5_busy", 32'(busy), 32'h0);
        rst = 1'b0; req = 4'b0101; #1;
        tick();
        check("t5_ptr0", 32'(gnt), 32'h1);
        req = 4'b0000; #1;
        tick(); tick();

`ifdef DAU_ARB_TIMEOUT_EN
        // Watchdog: owner holds request without issuing
        req = 4'b0001; #1;
        tick();
        check("t6_gnt", 32'(gnt), 32'h1);
        check("t6_tmo0", 32'(tmo), 32'h0);
        for (int i = 0; i < 7; i++) begin
            tick();
            check($sformatf("t6_hold%0d", i), 32'(gnt), 32'h1);
        end
        tick();
        check("t6_forced", 32'(gnt), 32'h0);
        check("t6_tmo1", 32'(tmo), 32'h1);
        req = 4'b0000; #1;
        tick();
        check("t6_tmo_end", 32'(tmo), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dau_instr_arb.md
DAU_INSTR_ARB -- requirements
Module: dau_instr_arb

Interface
REQ-001 Parameter N_REQ, default 4, number of instruction-issuing sequencers sharing one BCDU instruction port (2..8).
REQ-002 Parameter TIMEOUT_CYC, default 255, ownership watchdog limit in cycles; used only with DAU_ARB_TIMEOUT_EN.
REQ-003 i_clk  in  1  single clock; all state updates on rising edge.
REQ-004 i_rst  in  1  synchronous reset, active-high.
REQ-005 i_req  in  N_REQ  per-requester ownership request; held high from operation start until its last instruction is issued.
REQ-006 i_instr_valid  in  N_REQ  per-requester instruction valid.
REQ-007 i_instr  in  16*N_REQ  per-requester instruction; requester k occupies bits [16k+15:16k].
REQ-008 o_instr_accept  out  N_REQ  per-requester accept; forwarded BCDU accept for the owner only.
REQ-009 o_gnt  out  N_REQ  one-hot ownership grant, all-zero when no owner.
REQ-010 o_instr_valid  out  1  valid toward BCDU.
REQ-011 o_instr  out  16  instruction toward BCDU.
REQ-012 i_instr_accept  in  1  BCDU ready to take an instruction.
REQ-013 o_busy  out  1  high while any requester owns the port.
REQ-014 o_proto_err  out  1  sticky: a non-owner asserted i_instr_valid.

Function
REQ-015 FSM states S_IDLE, S_OWN, S_GAP; all state, grant, pointer and error flag are registered.
REQ-016 S_IDLE: if any i_req bit is high, grant the first requesting index at or after the round-robin pointer, modulo N_REQ; enter S_OWN next cycle (grant latency one cycle).
REQ-017 S_OWN: o_instr_valid = i_instr_valid[owner]; o_instr = owner's slice; o_instr_accept[owner] = i_instr_accept; all other accepts 0.
REQ-018 Outside S_OWN: o_instr_valid = 0; o_instr = NOP opcode with zero operands; all accepts 0.
REQ-019 Release: in S_OWN, when i_req[owner] = 0 and i_instr_valid[owner] = 0 in the same cycle, go to S_GAP and set pointer = owner+1 (wrap to 0 after N_REQ-1).
REQ-020 S_GAP lasts exactly one cycle, with o_gnt = 0, then S_IDLE; this prevents back-to-back sequences from interleaving.
REQ-021 An owner's trailing instruction that is valid after i_req drops is still passed; release waits for it to clear.
REQ-022 Requests from non-owners during S_OWN/S_GAP are held pending, never dropped; they are served by round-robin order.
REQ-023 Any i_instr_valid[k] = 1 with o_gnt[k] = 0 sets o_proto_err; it is cleared only by reset.
REQ-024 o_busy = (state == S_OWN).

Reset
REQ-025 On i_rst: state S_IDLE, o_gnt = 0, pointer 0, o_proto_err 0, watchdog 0; all outputs as in REQ-018.
REQ-026 Reset mid-ownership drops the grant in the next cycle, with no further accepts; requesters are reset by the same i_rst.

Configuration
REQ-027 Macro DAU_ARB_TIMEOUT_EN defined: a watchdog counts S_OWN cycles since the last accepted instruction (valid & accept).
REQ-028 When the watchdog reaches TIMEOUT_CYC, it forces the REQ-019 release and pulses o_timeout for one cycle.
REQ-029 DAU_ARB_TIMEOUT_EN undefined: no counter, no o_timeout port, and ownership is unbounded.

Structure
REQ-030 The shared package/header dau_arb_defs.vh holds the state encodings (S_IDLE=2'd0, S_OWN=2'd1, S_GAP=2'd2); NOP encoding comes from bcdu_op_codes.vh.
REQ-031 One sub-module, rr_pick, is combinational: it takes the request vector and pointer and returns a one-hot winner plus a found flag.

Verification
REQ-032 i_req=0001, owner issues 3 instrs with accept=1 -> o_gnt=0001 one cycle after req; 3 instrs on o_instr; S_GAP one cycle; then idle.
REQ-033 i_req=0101 simultaneously from reset -> grant 0001 first; after its release and gap, grant 0100; never overlapping.
REQ-034 Owner drops i_req while its last valid instr is stalled by i_instr_accept=0 for 4 cycles -> grant held; instr passes on accept; release follows.
REQ-035 Requester 2 asserts i_instr_valid while requester 0 owns -> o_proto_err=1, o_instr still owner's, o_instr_accept[2]=0.
REQ-036 i_rst pulsed in S_OWN -> next cycle o_gnt=0, o_instr_valid=0, o_proto_err=0, pointer 0.
REQ-037 DAU_ARB_TIMEOUT_EN, TIMEOUT_CYC=8, owner holds req with no valid -> forced release after 8 cycles, o_timeout one-cycle pulse.
